// File: rtl/ha1_task1_decoder.sv
// Registered 7-to-128 one-hot decoder, output split into four 32-bit banks X3..X0.
// Optional one-hot integrity checker enabled by defining DEC_ONEHOT_CHK_EN.
module ha1_task1_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  A,
  output logic [31:0] X3,
  output logic [31:0] X2,
  output logic [31:0] X1,
  output logic [31:0] X0,
  output logic        valid,
  output logic        err
);

  logic [3:0]  bank_sel;
  logic [31:0] line_sel;
  logic [31:0] x3_next, x2_next, x1_next, x0_next;

  // Bank predecode of A[6:5] gates a shared 5-to-32 line decode of A[4:0]
  always_comb begin
    bank_sel = 4'b0001 << A[6:5];
    line_sel = 32'h0000_0001 << A[4:0];
    x3_next  = bank_sel[3] ? line_sel : 32'h0;
    x2_next  = bank_sel[2] ? line_sel : 32'h0;
    x1_next  = bank_sel[1] ? line_sel : 32'h0;
    x0_next  = bank_sel[0] ? line_sel : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      X3    <= 32'h0;
      X2    <= 32'h0;
      X1    <= 32'h0;
      X0    <= 32'h0;
      valid <= 1'b0;
    end else if (en) begin
      X3    <= x3_next;
      X2    <= x2_next;
      X1    <= x1_next;
      X0    <= x0_next;
      valid <= 1'b1;
    end
  end

`ifdef DEC_ONEHOT_CHK_EN
  logic [127:0] out_vec;
  logic         is_onehot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
  always_comb begin
    out_vec   = {X3, X2, X1, X0};
    is_onehot = (out_vec != 128'h0) && ((out_vec & (out_vec - 128'h1)) == 128'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (valid && !is_onehot)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ha1_task1_decoder.sv
// Self-checking bench for ha1_task1_decoder: directed boundary cases plus randomized
// captures compared against an index-based reference model.
module tb_ha1_task1_decoder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [6:0]  A;
  logic [31:0] X3, X2, X1, X0;
  logic        valid;
  logic        err;

  int vectors;
  int miscompares;

  // Reference model: remembers the last captured index, not the bit pattern
  int ref_idx;
  logic ref_valid;

  ha1_task1_decoder dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .A     (A),
    .X3    (X3),
    .X2    (X2),
    .X1    (X1),
    .X0    (X0),
    .valid (valid),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] refVector();
    logic [127:0] v;
    v = '0;
    if (ref_valid)
      for (int i = 0; i < 128; i++)
        v[i] = (i == ref_idx);
    return v;
  endfunction

  task automatic checkModel(input string tag);
    checkOutput({tag, "_x"}, {X3, X2, X1, X0}, refVector());
    checkOutput({tag, "_valid"}, {127'h0, valid}, {127'h0, ref_valid});
    checkOutput({tag, "_err"}, {127'h0, err}, 128'h0);
  endtask

  task automatic applyStimulus(input logic e, input logic [6:0] a);
    @(negedge clk);
    en = e;
    A  = a;
    @(posedge clk);
    if (e) begin
      ref_idx   = int'(a);
      ref_valid = 1'b1;
    end
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ref_idx     = 0;
    ref_valid   = 1'b0;

    // Reset held with clocks running and a capture request pending
    rst = 1'b1;
    en  = 1'b1;
    A   = 7'h55;
    repeat (3) @(posedge clk);
    #1;
    checkModel("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // Full sweep, one capture per clock
    for (int i = 0; i < 128; i++) begin
      applyStimulus(1'b1, 7'(i));
      checkModel($sformatf("sweep_%0d", i));
      if (i == 0)   checkOutput("bound_a0_x0", {96'h0, X0}, {96'h0, 32'h1});
      if (i == 31)  checkOutput("bound_a31_x0", {96'h0, X0}, {96'h0, 32'h8000_0000});
      if (i == 32)  checkOutput("bound_a32", {X1, X0}, {32'h1, 32'h0});
      if (i == 127) checkOutput("bound_a127", {X3, X2, X1, X0}, {32'h8000_0000, 96'h0});
    end

    // Hold while en=0
    applyStimulus(1'b1, 7'd40);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 7'd100);
      checkOutput("hold_x", {X3, X2, X1, X0}, {64'h0, 32'h0000_0100, 32'h0});
      checkModel("hold_model");
    end

    // Back-to-back 127 then 0
    applyStimulus(1'b1, 7'd127);
    checkOutput("b2b_127", {X3, X2, X1, X0}, {32'h8000_0000, 96'h0});
    applyStimulus(1'b1, 7'd0);
    checkOutput("b2b_0", {X3, X2, X1, X0}, {96'h0, 32'h1});

    // Asynchronous reset pulse between clock edges
    applyStimulus(1'b1, 7'd64);
    checkOutput("pre_rst_x2", {96'h0, X2}, {96'h0, 32'h1});
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    ref_valid = 1'b0;
    checkOutput("async_rst_x2", {96'h0, X2}, 128'h0);
    checkModel("async_rst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 7'd17);
    checkModel("post_rst_capture");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic       e;
      logic [6:0] a;
      e = ($urandom_range(0, 3) != 0);
      a = 7'($urandom_range(0, 127));
      applyStimulus(e, a);
      checkModel("random");
    end

`ifdef DEC_ONEHOT_CHK_EN
    // Corrupt the outputs so two bits are set; the checker must latch err
    @(negedge clk);
    en = 1'b0;
    force dut.X0 = 32'h0000_0003;
    @(posedge clk);
    #1;
    checkOutput("chk_err_set", {127'h0, err}, {127'h0, 1'b1});
    @(negedge clk);
    release dut.X0;
    applyStimulus(1'b1, 7'd5);
    applyStimulus(1'b1, 7'd6);
    checkOutput("chk_err_sticky", {127'h0, err}, {127'h0, 1'b1});
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("chk_err_cleared", {127'h0, err}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
